muldiv_seq: RTL
===============

// Module: muldiv_seq
// PURPOSE
//   Iterative RV32M multiply/divide sequencer beside the EX-stage ALU. Accepts one op
//   from EX, runs a radix-2 shift-add / shift-subtract loop over XLEN cycles, then
//   returns a one-cycle result pulse to the EX/MEM path. Its busy output feeds the
//   hazard unit, which stalls IF/ID/EX while an op is in flight.
// PARAMETERS
//   XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//   clk      in   1     clock, rising edge
//   reset    in   1     synchronous, active-high
//   startE   in   1     launch op; sampled only in IDLE
//   funct3E  in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//   srcAE    in   XLEN  rs1 operand (multiplicand / dividend)
//   srcBE    in   XLEN  rs2 operand (multiplier / divisor)
//   flushE   in   1     abort in-flight op (branch mispredict / trap)
//   busyE    out  1     1 when state != IDLE
//   doneE    out  1     one-cycle pulse, resultE valid
//   resultE  out  XLEN  final result; holds last value until next done
// BEHAVIOUR
//   - Reset: state=IDLE, busyE=0, doneE=0, resultE=0, all internal regs 0.
//   - FSM: IDLE -> CALC -> DONE -> IDLE. CALC counter counts XLEN-1 down to 0.
//   - IDLE & startE: latch funct3, |srcA|,|srcB| (signed ops per funct3), result signs;
//     go CALC. Special divide cases bypass CALC and go straight to DONE.
//   - CALC: one iteration per cycle; 2*XLEN-bit product accumulator (mul) or
//     XLEN-bit remainder/quotient shift pair (div); counter==0 -> DONE.
//   - DONE: doneE=1 for exactly one cycle, resultE updated same cycle, sign fix-up
//     applied (two's complement negate when latched sign set); next state IDLE.
//   - Latency: normal op doneE rises XLEN+1 cycles after the startE edge (33 at
//     XLEN=32); special-case divides: 1 cycle.
//   - Result select: MUL low half; MULH/MULHSU/MULHU high half (MULHSU: srcA signed,
//     srcB unsigned); DIV/DIVU quotient; REM/REMU remainder. REM sign follows dividend.
//   - Divide by zero: quotient = all ones (DIV and DIVU), remainder = dividend.
//   - Signed overflow (DIV/REM, srcA=0x80000000, srcB=0xFFFFFFFF): quotient=0x80000000,
//     remainder=0.
//   - startE while busyE=1: ignored; no queueing. startE in the same cycle as the
//     DONE pulse is ignored; launch takes effect from IDLE only.
//   - flushE: any state -> IDLE next cycle, no doneE, resultE unchanged. flushE with
//     startE in IDLE: flush wins, op not launched.
//   - reset asserted mid-op: same as reset values above, next cycle IDLE.
//   - Operands are latched at start; srcAE/srcBE may change during CALC.
// CONFIGURATION
//   MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU computed with one combinational
//     2*XLEN-bit multiply; IDLE -> DONE directly, doneE 1 cycle after startE.
//     Divides remain iterative.
//   Not defined: all multiplies iterative, XLEN+1 cycle latency as above.
// TESTING
//   1 MUL 7 x -3 (0x7, 0xFFFFFFFD) -> doneE at cycle 33 (1 w/ FAST_MUL), result 0xFFFFFFEB
//   2 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000
//   3 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2
//   4 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000,
//     REM -> 0; each doneE 1 cycle after start
//   5 DIVU launched, flushE at iteration 10 -> busyE=0 next cycle, no doneE, resultE
//     unchanged; new startE next cycle completes normally
//   6 startE pulsed during CALC and on DONE cycle -> ignored, exactly one doneE;
//     reset during CALC -> busyE=0, doneE=0, resultE=0 next cycle

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer (radix-2 shift-add / restoring shift-subtract).
// Define MULDIV_FAST_MUL_EN to compute multiplies with a single combinational multiply.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            startE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] srcAE,
    input  logic [XLEN-1:0] srcBE,
    input  logic            flushE,
    output logic            busyE,
    output logic            doneE,
    output logic [XLEN-1:0] resultE
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   res_q, res_d;

    // Operand decode for the op being offered by EX.
    logic            is_div, a_signed, b_signed, sa, sb, neg_in;
    logic            div_zero, div_ovf, special, fast_mul, launch;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        is_div   = funct3E[2];
        a_signed = is_div ? ~funct3E[0] : (funct3E != 3'b011);
        b_signed = is_div ? ~funct3E[0] : ~funct3E[1];
        sa       = a_signed & srcAE[XLEN-1];
        sb       = b_signed & srcBE[XLEN-1];
        a_mag    = sa ? -srcAE : srcAE;
        b_mag    = sb ? -srcBE : srcBE;
        // Remainder takes the dividend's sign; everything else the product/quotient sign.
        neg_in   = (is_div & funct3E[1]) ? sa : (sa ^ sb);
        div_zero = is_div & (srcBE == '0);
        div_ovf  = is_div & ~funct3E[0] & (srcAE == {1'b1, {(XLEN-1){1'b0}}}) & (srcBE == '1);
        special  = div_zero | div_ovf;
`ifdef MULDIV_FAST_MUL_EN
        fast_mul = ~is_div;
`else
        fast_mul = 1'b0;
`endif
        launch   = (state_q == S_IDLE) & startE & ~flushE & ~done_q;
    end

    // One iteration step: hi half is the running sum / remainder, lo half the multiplier / quotient.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    // Sign fix-up and result selection, consumed in DONE.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_raw, div_fix, res_sel;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        div_raw  = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        div_fix  = neg_q ? -div_raw : div_raw;
        if (f3_q[2])             res_sel = div_fix;
        else if (f3_q == 3'b000) res_sel = prod_fix[XLEN-1:0];
        else                     res_sel = prod_fix[2*XLEN-1:XLEN];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; flush has priority over everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (launch) state_d = (special | fast_mul) ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flushE) state_d = S_IDLE;
    end

    // Outputs.
    always_comb begin
        busyE   = (state_q != S_IDLE);
        doneE   = done_q;
        resultE = res_q;
    end

    // Datapath next-state.
    always_comb begin
        // NOTE: every _d starts as a hold of its _q so no path leaves it unassigned (no latches).
        f3_d   = f3_q;
        opnd_d = opnd_q;
        acc_d  = acc_q;
        neg_d  = neg_q;
        cnt_d  = cnt_q;
        if (launch) begin
            f3_d   = funct3E;
            neg_d  = neg_in;
            opnd_d = is_div ? b_mag : a_mag;
            acc_d  = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            cnt_d  = CW'(XLEN - 1);
            if (div_zero) begin
                acc_d = {srcAE, {XLEN{1'b1}}};
                neg_d = 1'b0;
            end else if (div_ovf) begin
                acc_d = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                neg_d = 1'b0;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) begin
                acc_d = (2*XLEN)'(a_mag) * (2*XLEN)'(b_mag);
            end
`endif
        end else if (state_q == S_CALC) begin
            acc_d = f3_q[2] ? div_next : mul_next;
            cnt_d = cnt_q - 1'b1;
        end
        done_d = (state_q == S_DONE) & ~flushE;
        res_d  = done_d ? res_sel : res_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset clears every register, including the datapath, so state is fully deterministic.
        if (reset) begin
            f3_q   <= '0;
            opnd_q <= '0;
            acc_q  <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            res_q  <= '0;
        end else begin
            f3_q   <= f3_d;
            opnd_q <= opnd_d;
            acc_q  <= acc_d;
            neg_q  <= neg_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            res_q  <= res_d;
        end
    end

endmodule
